// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
//   Shared definitions for the boot-time program loader: FSM state encoding,
//   default start-of-frame marker, byte-index width, length-field width and
//   the running payload checksum helper.
//   Optional feature macro used by the loader: PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CHECK  = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERROR  = 3'd7
    } state_e;

    localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

    // Four bytes per instruction word -> two index bits.
    localparam int BYTE_IDX_W = 2;

    // The frame length field is two bytes wide.
    localparam int LEN_W = 16;

    // Running XOR over payload bytes.
    function automatic logic [7:0] csum_update(input logic [7:0] acc,
                                               input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/prog_loader_assembler.sv
// prog_loader_assembler
//   Little-endian 4-byte word assembler. Each shifted byte enters at the top
//   of the word, so after four shifts the first byte sits in bits 7:0.
//   Ports:
//     clock, reset    : clock and asynchronous active-low reset
//     clear           : restart byte counting at byte 0 (start of payload)
//     shift_en        : accept in_byte into the word
//     in_byte         : payload byte
//     word            : assembled word (registered)
//     byte_idx        : index of the next byte to be accepted (0..3)
//     word_ready      : high for the one cycle after the 4th byte is shifted
module prog_loader_assembler
    import prog_loader_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic [7:0]            in_byte,
    output logic [31:0]           word,
    output logic [BYTE_IDX_W-1:0] byte_idx,
    output logic                  word_ready
);

    localparam logic [BYTE_IDX_W-1:0] IDX_ZERO = '0;
    localparam logic [BYTE_IDX_W-1:0] IDX_LAST = '1;
    localparam logic [BYTE_IDX_W-1:0] IDX_ONE  = BYTE_IDX_W'(1);

    logic [31:0]           word_r;
    logic [BYTE_IDX_W-1:0] byte_idx_r;
    logic                  word_ready_r;

    // Shift register, byte counter and completion flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_r       <= 32'h0000_0000;
            byte_idx_r   <= IDX_ZERO;
            word_ready_r <= 1'b0;
        end else if (clear) begin
            byte_idx_r   <= IDX_ZERO;
            word_ready_r <= 1'b0;
        end else if (shift_en) begin
            word_r       <= {in_byte, word_r[31:8]};
            byte_idx_r   <= byte_idx_r + IDX_ONE;
            word_ready_r <= (byte_idx_r == IDX_LAST);
        end else begin
            word_ready_r <= 1'b0;
        end
    end

    assign word       = word_r;
    assign byte_idx   = byte_idx_r;
    assign word_ready = word_ready_r;

endmodule

// File: rtl/prog_loader.sv
// prog_loader
//   Boot-time instruction-memory writer. Receives a framed byte stream
//   (SOF, LEN_LO, LEN_HI, LEN*4 payload bytes [, checksum]) and writes each
//   little-endian 32-bit word to consecutive word addresses starting at 0.
//   The CPU is held disabled until a complete image has been accepted.
//   Optional feature macro: PROG_LOADER_CHECKSUM_EN adds a trailing XOR
//   checksum byte verified in the CHECK state.
//   Ports:
//     clock, reset       : clock, asynchronous active-low reset
//     in_valid/in_data   : byte stream, transfer on in_valid && in_ready
//     in_ready           : low only during the one-cycle WRITE state
//     mem_write_enable   : one-cycle write strobe
//     mem_address        : word address of the write
//     mem_write_data     : instruction word to write
//     cpu_enable         : high only in DONE
//     busy               : frame in progress (LEN_LO..CHECK)
//     done / error       : image accepted / frame rejected
//     word_count         : words written in the current frame
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 8,
    parameter int         MAX_WORDS  = 256,
    parameter logic [7:0] SOF_BYTE   = SOF_BYTE_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic                  cpu_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int                    CNT_W    = ADDR_WIDTH + 1;
    localparam logic [LEN_W-1:0]      MAX_LEN  = LEN_W'(MAX_WORDS);
    localparam logic [LEN_W-1:0]      LEN_ZERO = '0;
    localparam logic [CNT_W-1:0]      CNT_ZERO = '0;
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [BYTE_IDX_W-1:0] IDX_LAST = '1;

`ifdef PROG_LOADER_CHECKSUM_EN
    // With a checksum, the end of payload leads to CHECK instead of DONE.
    localparam state_e END_STATE = ST_CHECK;
`else
    localparam state_e END_STATE = ST_DONE;
`endif

    state_e                state_r;
    state_e                next_state_s;
    logic [7:0]            len_lo_r;
    logic [LEN_W-1:0]      len_r;
    logic [CNT_W-1:0]      word_count_r;
    logic                  in_ready_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  error_r;
    logic                  cpu_enable_r;

    logic                  accept_s;
    logic                  sof_s;
    logic [LEN_W-1:0]      len_in_s;
    logic [CNT_W-1:0]      wc_inc_s;
    logic                  last_word_s;
    logic                  asm_clear_s;
    logic                  asm_shift_s;
    logic [31:0]           asm_word_s;
    logic [BYTE_IDX_W-1:0] asm_byte_idx_s;
    logic                  asm_word_ready_s;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]            csum_r;
`endif

    // The handshake is judged against the registered ready the source sees.
    assign accept_s    = in_valid && in_ready_r;
    assign sof_s       = (in_data == SOF_BYTE);
    assign len_in_s    = {in_data, len_lo_r};
    assign wc_inc_s    = word_count_r + CNT_ONE;
    assign last_word_s = (LEN_W'(wc_inc_s) == len_r);

    prog_loader_assembler u_assembler (
        .clock      (clock),
        .reset      (reset),
        .clear      (asm_clear_s),
        .shift_en   (asm_shift_s),
        .in_byte    (in_data),
        .word       (asm_word_s),
        .byte_idx   (asm_byte_idx_s),
        .word_ready (asm_word_ready_s)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and assembler controls.
    always_comb begin
        next_state_s = state_r;
        asm_clear_s  = 1'b0;
        asm_shift_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && sof_s) begin
                    next_state_s = ST_LEN_LO;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LEN_LO: begin
                if (accept_s) begin
                    next_state_s = ST_LEN_HI;
                end else begin
                    next_state_s = ST_LEN_LO;
                end
            end
            ST_LEN_HI: begin
                if (accept_s) begin
                    if (len_in_s > MAX_LEN) begin
                        next_state_s = ST_ERROR;
                    end else if (len_in_s == LEN_ZERO) begin
                        next_state_s = END_STATE;
                    end else begin
                        next_state_s = ST_DATA;
                        asm_clear_s  = 1'b1;
                    end
                end else begin
                    next_state_s = ST_LEN_HI;
                end
            end
            ST_DATA: begin
                // SOF bytes here are ordinary payload; no mid-frame resync.
                if (accept_s) begin
                    asm_shift_s = 1'b1;
                    if (asm_byte_idx_s == IDX_LAST) begin
                        next_state_s = ST_WRITE;
                    end else begin
                        next_state_s = ST_DATA;
                    end
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_WRITE: begin
                if (last_word_s) begin
                    next_state_s = END_STATE;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept_s) begin
                    if (in_data == csum_r) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_ERROR;
                    end
                end else begin
                    next_state_s = ST_CHECK;
                end
            end
`endif
            ST_DONE, ST_ERROR: begin
                if (accept_s && sof_s) begin
                    next_state_s = ST_LEN_LO;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Length capture and written-word counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len_lo_r     <= 8'h00;
            len_r        <= LEN_ZERO;
            word_count_r <= CNT_ZERO;
        end else begin
            if ((state_r == ST_LEN_LO) && accept_s) begin
                len_lo_r <= in_data;
            end
            if ((state_r == ST_LEN_HI) && accept_s) begin
                len_r        <= len_in_s;
                word_count_r <= CNT_ZERO;
            end else if (state_r == ST_WRITE) begin
                word_count_r <= wc_inc_s;
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Running XOR of payload bytes, restarted with each new frame length.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            csum_r <= 8'h00;
        end else if ((state_r == ST_LEN_HI) && accept_s) begin
            csum_r <= 8'h00;
        end else if (asm_shift_s) begin
            csum_r <= csum_update(csum_r, in_data);
        end
    end
`endif

    // Status outputs registered from the upcoming state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_ready_r   <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            cpu_enable_r <= 1'b0;
        end else begin
            in_ready_r   <= (next_state_s != ST_WRITE);
            busy_r       <= (next_state_s inside {ST_LEN_LO, ST_LEN_HI, ST_DATA,
                                                  ST_WRITE, ST_CHECK});
            done_r       <= (next_state_s == ST_DONE);
            error_r      <= (next_state_s == ST_ERROR);
            cpu_enable_r <= (next_state_s == ST_DONE);
        end
    end

    // The assembler flag is high exactly during WRITE; the counter still
    // holds the pre-increment value there, which is the write address.
    assign in_ready         = in_ready_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign error            = error_r;
    assign cpu_enable       = cpu_enable_r;
    assign mem_write_enable = asm_word_ready_s;
    assign mem_write_data   = asm_word_s;
    assign mem_address      = word_count_r[ADDR_WIDTH-1:0];
    assign word_count       = word_count_r;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
//   Directed bench for prog_loader. Expected memory writes are queued when a
//   frame is sent and checked by a write monitor as strobes appear.
//   Honours PROG_LOADER_CHECKSUM_EN by appending checksum bytes.
module tb_prog_loader;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_write_enable;
    logic [7:0]  mem_address;
    logic [31:0] mem_write_data;
    logic        cpu_enable;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  word_count;

    int          checks;
    int          errors;
    logic [39:0] exp_q[$];
    logic [39:0] mon_e;

    prog_loader dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .cpu_enable       (cpu_enable),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .word_count       (word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one byte after an optional idle gap; waits (bounded) for ready.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        in_valid = 1'b0;
        repeat (gap) @(negedge clock);
        @(negedge clock);
        while ((in_ready !== 1'b1) && (n < 50)) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 40'(in_ready), 40'd1);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_write(input logic [7:0] addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 40'(in_ready), 40'd1);
        chk({tag, "_we"},       40'(mem_write_enable), 40'd0);
        chk({tag, "_addr"},     40'(mem_address), 40'd0);
        chk({tag, "_wdata"},    40'(mem_write_data), 40'd0);
        chk({tag, "_cpu_en"},   40'(cpu_enable), 40'd0);
        chk({tag, "_busy"},     40'(busy), 40'd0);
        chk({tag, "_done"},     40'(done), 40'd0);
        chk({tag, "_error"},    40'(error), 40'd0);
        chk({tag, "_wcount"},   40'(word_count), 40'd0);
    endtask

    task automatic settle();
        repeat (3) @(negedge clock);
    endtask

    // Write monitor: every strobe must match the oldest queued write.
    always @(negedge clock) begin
        if ((reset === 1'b1) && (mem_write_enable === 1'b1)) begin
            chk("wr_in_ready_low", 40'(in_ready), 40'd0);
            if (exp_q.size() == 0) begin
                chk("wr_expected", 40'(exp_q.size()), 40'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 40'(mem_address), 40'(mon_e[39:32]));
                chk("wr_data", 40'(mem_write_data), 40'(mon_e[31:0]));
            end
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset state, then non-SOF bytes in IDLE are discarded.
        repeat (2) @(negedge clock);
        chk_reset_outputs("rst");
        reset = 1'b1;
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        settle();
        chk("idle_busy", 40'(busy), 40'd0);
        chk("idle_done", 40'(done), 40'd0);
        chk("idle_ready", 40'(in_ready), 40'd1);

        // Normal two-word load.
        expect_write(8'd0, 32'h0050_0513);
        expect_write(8'd1, 32'h00A0_0593);
        send_byte(8'hA5, 0);
        chk("sof_busy", 40'(busy), 40'd1);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h05, 0);
        send_byte(8'h50, 0);
        send_byte(8'h00, 0);
        send_byte(8'h93, 0);
        send_byte(8'h05, 0);
        send_byte(8'hA0, 0);
        send_byte(8'h00, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h13 ^ 8'h05 ^ 8'h50 ^ 8'h00 ^ 8'h93 ^ 8'h05 ^ 8'hA0 ^ 8'h00, 0);
`endif
        settle();
        chk("load_done", 40'(done), 40'd1);
        chk("load_cpu_en", 40'(cpu_enable), 40'd1);
        chk("load_wcount", 40'(word_count), 40'd2);
        chk("load_busy", 40'(busy), 40'd0);
        chk("load_sb_empty", 40'(exp_q.size()), 40'd0);

        // Oversize length: SOF from DONE drops done/cpu_enable at once.
        send_byte(8'hA5, 0);
        chk("resof_done", 40'(done), 40'd0);
        chk("resof_cpu_en", 40'(cpu_enable), 40'd0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        settle();
        chk("ovr_error", 40'(error), 40'd1);
        chk("ovr_cpu_en", 40'(cpu_enable), 40'd0);
        chk("ovr_busy", 40'(busy), 40'd0);
        send_byte(8'hA5, 0);
        chk("err_sof_error", 40'(error), 40'd0);
        chk("err_sof_busy", 40'(busy), 40'd1);

        // Zero length on the frame just opened.
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        chk("zero_wait_csum", 40'(done), 40'd0);
        send_byte(8'h00, 0);
`endif
        settle();
        chk("zero_done", 40'(done), 40'd1);
        chk("zero_wcount", 40'(word_count), 40'd0);

        // SOF value inside the payload is ordinary data.
        expect_write(8'd0, 32'hA5A5_A5A5);
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        repeat (4) send_byte(8'hA5, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        settle();
        chk("sofdata_done", 40'(done), 40'd1);
        chk("sofdata_wcount", 40'(word_count), 40'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Good and bad trailing checksum.
        expect_write(8'd0, 32'h0050_0513);
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h05, 0); send_byte(8'h50, 0); send_byte(8'h00, 0);
        send_byte(8'h46, 0);
        settle();
        chk("csum_ok_done", 40'(done), 40'd1);
        expect_write(8'd0, 32'h0050_0513);
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h05, 0); send_byte(8'h50, 0); send_byte(8'h00, 0);
        send_byte(8'h47, 0);
        settle();
        chk("csum_bad_error", 40'(error), 40'd1);
        chk("csum_bad_cpu_en", 40'(cpu_enable), 40'd0);
        chk("csum_bad_sb_empty", 40'(exp_q.size()), 40'd0);
`endif

        // Reset after 6 bytes of a 2-word frame: outputs clear immediately.
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h05, 0);
        send_byte(8'h50, 0);
        chk("mid_busy", 40'(busy), 40'd1);
        reset = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clock);
        reset = 1'b1;

        // Reload with 3-cycle idle gaps before every byte.
        expect_write(8'd0, 32'h0050_0513);
        expect_write(8'd1, 32'h00A0_0593);
        send_byte(8'hA5, 3);
        send_byte(8'h02, 3);
        send_byte(8'h00, 3);
        send_byte(8'h13, 3);
        send_byte(8'h05, 3);
        send_byte(8'h50, 3);
        send_byte(8'h00, 3);
        send_byte(8'h93, 3);
        send_byte(8'h05, 3);
        send_byte(8'hA0, 3);
        send_byte(8'h00, 3);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h70, 3);
`endif
        settle();
        chk("stall_done", 40'(done), 40'd1);
        chk("stall_cpu_en", 40'(cpu_enable), 40'd1);
        chk("stall_wcount", 40'(word_count), 40'd2);
        chk("final_sb_empty", 40'(exp_q.size()), 40'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
